// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter
//    Round-robin arbiter in front of the select input of an 8:1 mux.
//    Eight requesters share a single downstream consumer. A tenure
//    lasts until its owner drops its request or has had MAX_HOLD
//    accepted beats. Priority then rotates to the requester after
//    the owner. The next owner is loaded on the same edge, so there
//    is no gap cycle between tenures.
//
// Ports
//    clk    rising-edge clock
//    rst    synchronous reset, active high
//    req    request vector; req[i] is high while mux input i holds data
//    ready  downstream accepts the mux output this cycle
//    grant  one-hot grant (registered), all-zero when idle
//    sel    mux select (registered), index of the granted requester
//    valid  combinational: tenure active and owner still requesting
//    busy   tenure active (registered)
//
// state | meaning
// IDLE  | no owner; arbitrate from ptr whenever any request is seen
// GRANT | sel owns the mux; count beats until drop or quota

module rr_mux8_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       ready,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       valid,
   output logic       busy
);

   typedef enum logic {IDLE, GRANT} state_e;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

   state_e     state_q;
   logic [7:0] grant_q;
   logic [2:0] sel_q;
   logic [2:0] ptr_q;
   logic [2:0] ptr_d;
   logic       busy_q;
   logic [3:0] cnt_q;

   logic       beat;
   logic       tenure_end;
   logic [2:0] arb_ptr;
   logic [3:0] win;
   logic       win_vld;
   logic [2:0] win_idx;

   // Returns {found, index} of the first set bit of r at or after p (mod 8).
   // Scanning from the far end lets the nearest hit overwrite the others.
   function automatic logic [3:0] arb(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = p + 3'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign valid      = busy_q & req[sel_q];
   assign beat       = valid & ready;
   assign tenure_end = !req[sel_q] || (beat && (cnt_q == LAST_BEAT));
   assign ptr_d      = sel_q + 3'd1;

   // At tenure end the new priority pointer is used on the same edge.
   assign arb_ptr = (state_q == GRANT) ? ptr_d : ptr_q;
   assign win     = arb(req, arb_ptr);
   assign win_vld = win[3];
   assign win_idx = win[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  state_q <= GRANT;
                  grant_q <= 8'(1) << win_idx;
                  sel_q   <= win_idx;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            GRANT: begin
               if (tenure_end) begin
                  ptr_q <= ptr_d;
                  cnt_q <= '0;
                  if (win_vld) begin
                     grant_q <= 8'(1) << win_idx;
                     sel_q   <= win_idx;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                  end
               end else if (beat) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter (MAX_HOLD = 4).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point, well away from the next active edge.

module tb_rr_mux8_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       ready;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // Observed bundle: {grant, sel, valid, busy}
   logic [12:0] obs;
   logic [12:0] exp_v;
   assign obs = {grant, sel, valid, busy};

   rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .ready (ready),
      .grant (grant),
      .sel   (sel),
      .valid (valid),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req   = 8'h00;
      ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      req   = 8'hFF;
      ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step();
         exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      rst   = 1'b0;
      ready = 1'b1;
      step();
      exp_v = {8'h01, 3'd0, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL reset_release got=%h exp=%h", obs, exp_v);
      end
   endtask

   // Continues straight from test_reset: owner 0 was just granted, req=FF, ready=1.
   task automatic test_rotation();
      for (int o = 0; o < 9; o++) begin
         for (int k = 0; k < 4; k++) begin
            exp_v = {8'(1 << (o % 8)), 3'(o % 8), 1'b1, 1'b1};
            total++;
            if (obs !== exp_v) begin
               bad++;
               $display("FAIL rotation owner=%0d beat=%0d got=%h exp=%h", o % 8, k, obs, exp_v);
            end
            step();
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      req   = 8'h22;
      ready = 1'b1;
      step();
      exp_v = {8'h02, 3'd1, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL early_first got=%h exp=%h", obs, exp_v);
      end
      step();
      step();
      req = 8'h20;
      #1;
      total++;
      if (valid !== 1'b0) begin
         bad++;
         $display("FAIL early_valid_drop got=%b exp=0", valid);
      end
      step();
      exp_v = {8'h20, 3'd5, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL early_handoff got=%h exp=%h", obs, exp_v);
      end
      req = 8'h00;
      step();
      // sel keeps its last value in IDLE
      exp_v = {8'h00, 3'd5, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL early_idle got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req   = 8'h08;
      ready = 1'b0;
      step();
      exp_v = {8'h08, 3'd3, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL bp_grant got=%h exp=%h", obs, exp_v);
      end
      for (int c = 0; c < 10; c++) begin
         step();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL bp_stall cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL bp_regrant cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      // Fresh tenure for owner 3 with cnt=0; requester 4 waits its turn.
      req = 8'h18;
      for (int c = 0; c < 2; c++) begin
         step();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL bp_hold_a cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL bp_hold_stall cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      ready = 1'b1;
      step();
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL bp_hold_b got=%h exp=%h", obs, exp_v);
      end
      step();
      exp_v = {8'h10, 3'd4, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL bp_rotate got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_no_preempt_wrap();
      do_reset();
      req   = 8'h40;
      ready = 1'b1;
      step();
      exp_v = {8'h40, 3'd6, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL np_grant got=%h exp=%h", obs, exp_v);
      end
      req = 8'h41;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (obs !== exp_v) begin
            bad++;
            $display("FAIL np_hold cyc=%0d got=%h exp=%h", c, obs, exp_v);
         end
      end
      step();
      exp_v = {8'h01, 3'd0, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL np_wrap got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      req   = 8'h20;
      ready = 1'b1;
      step();
      step();
      exp_v = {8'h20, 3'd5, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL mr_owner got=%h exp=%h", obs, exp_v);
      end
      rst = 1'b1;
      req = 8'h21;
      step();
      exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL mr_cleared got=%h exp=%h", obs, exp_v);
      end
      rst = 1'b0;
      step();
      exp_v = {8'h01, 3'd0, 1'b1, 1'b1};
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL mr_ptr_zero got=%h exp=%h", obs, exp_v);
      end
   endtask

   initial begin
      rst   = 1'b1;
      req   = 8'h00;
      ready = 1'b0;
      #2;
      test_reset();
      test_rotation();
      test_early_release();
      test_backpressure();
      test_no_preempt_wrap();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
